mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arb_grant.sv | 23 ++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic port_id_t;

  localparam int DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and shared memory port bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_rd;
  logic              req0_wr;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [DATA_W-1:0] req0_rdata;
  logic              ready0;
  logic              req1_rd;
  logic              req1_wr;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [DATA_W-1:0] req1_rdata;
  logic              ready1;
  logic              freeze;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [DATA_W-1:0] mem_data;

  modport slave (
    input  req0_rd, req0_wr, req0_addr, req0_wdata,
    input  req1_rd, req1_wr, req1_addr, req1_wdata,
    input  mem_data,
    output req0_rdata, ready0, req1_rdata, ready1, freeze,
    output mem_address, mem_write_data, mem_r_en, mem_w_en
  );

  modport master (
    output req0_rd, req0_wr, req0_addr, req0_wdata,
    output req1_rd, req1_wr, req1_addr, req1_wdata,
    output mem_data,
    input  req0_rdata, ready0, req1_rdata, ready1, freeze,
    input  mem_address, mem_write_data, mem_r_en, mem_w_en
  );
endinterface

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - grant selection between the two requesters
// MEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  port_id_t   last_grant_i,
`endif
  input  logic [1:0] req_i,
  output port_id_t   grant_o,
  output logic       valid_o
);

  assign valid_o = |req_i;

`ifdef MEM_ARB_RR_EN
  // On contention the port not served last time wins.
  assign grant_o = (&req_i) ? ~last_grant_i : (req_i[1] & ~req_i[0]);
`else
  assign grant_o = req_i[1] & ~req_i[0];
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter onto one fixed-latency memory port
// MEM_ARB_RR_EN enables round-robin arbitration (default: port 0 priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  port_id_t          grant_q, grant_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        req;
  port_id_t          arb_grant;
  logic              arb_valid;
  logic              ready0, ready1, mem_r_en, mem_w_en;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;

  assign req = {bus.req1_rd | bus.req1_wr, bus.req0_rd | bus.req0_wr};

`ifdef MEM_ARB_RR_EN
  port_id_t last_grant_q, last_grant_d;

  mem_arb_grant u_grant (
    .last_grant_i(last_grant_q),
    .req_i       (req),
    .grant_o     (arb_grant),
    .valid_o     (arb_valid)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && arb_valid) last_grant_d = arb_grant;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
`else
  mem_arb_grant u_grant (
    .req_i  (req),
    .grant_o(arb_grant),
    .valid_o(arb_valid)
  );
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    grant_d        = grant_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    ready0         = 1'b0;
    ready1         = 1'b0;
    mem_r_en       = 1'b0;
    mem_w_en       = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          wr_d    = arb_grant ? bus.req1_wr    : bus.req0_wr;
          addr_d  = arb_grant ? bus.req1_addr  : bus.req0_addr;
          wdata_d = arb_grant ? bus.req1_wdata : bus.req0_wdata;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        mem_r_en       = ~wr_q;
        // Writes get a single strobe in the last cycle of the hold window.
        mem_w_en       = wr_q && (cnt_q == 4'd0);
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!wr_q) begin
            if (grant_q) rdata1_d = bus.mem_data;
            else         rdata0_d = bus.mem_data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        ready0  = (grant_q == 1'b0);
        ready1  = (grant_q == 1'b1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.req0_rdata     = rdata0_q;
  assign bus.req1_rdata     = rdata1_q;
  assign bus.ready0         = ready0;
  assign bus.ready1         = ready1;
  assign bus.freeze         = req[0] & ~ready0;
  assign bus.mem_address    = mem_address;
  assign bus.mem_write_data = mem_write_data;
  assign bus.mem_r_en       = mem_r_en;
  assign bus.mem_w_en       = mem_w_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Honors MEM_ARB_RR_EN for the contention scenario.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WC = 2;

  logic clock = 1'b0;
  logic reset;
  logic mem_init;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Byte-addressed memory, big-endian word view; reset image byte i = i+1.
  logic [7:0] mem [0:255];
  logic [7:0] ma;

  always_comb begin
    ma = bus.mem_address[7:0];
    bus.mem_data = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};
  end

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 1);
    end else if (bus.mem_w_en) begin
      mem[ma]         <= bus.mem_write_data[31:24];
      mem[ma + 8'd1]  <= bus.mem_write_data[23:16];
      mem[ma + 8'd2]  <= bus.mem_write_data[15:8];
      mem[ma + 8'd3]  <= bus.mem_write_data[7:0];
    end
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  task automatic clear_reqs();
    bus.req0_rd = 1'b0; bus.req0_wr = 1'b0;
    bus.req1_rd = 1'b0; bus.req1_wr = 1'b0;
  endtask

  task automatic set_req(input int port, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0_rd = rd; bus.req0_wr = wr; bus.req0_addr = addr; bus.req0_wdata = wdata;
    end else begin
      bus.req1_rd = rd; bus.req1_wr = wr; bus.req1_addr = addr; bus.req1_wdata = wdata;
    end
  endtask

  // One transaction; reports latency in cycles and strobe/freeze cycle counts.
  task automatic do_access(input int port, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int wen, output int ren, output int frz);
    @(negedge clock);
    set_req(port, rd, wr, addr, wdata);
    #1;
    frz = bus.freeze ? 1 : 0;
    lat = -1; wen = 0; ren = 0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clock);
      if (bus.mem_w_en) wen++;
      if (bus.mem_r_en) ren++;
      if (bus.freeze) frz++;
      if ((port == 0) ? bus.ready0 : bus.ready1) begin
        lat = k;
        clear_reqs();
      end
    end
    clear_reqs();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_init = 1'b1;
    clear_reqs();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clock);
    mem_init = 1'b0;
    checks++;
    if (bus.ready0 !== 1'b0 || bus.ready1 !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b want 00", bus.ready0, bus.ready1);
    end
    checks++;
    if (bus.mem_r_en !== 1'b0 || bus.mem_w_en !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got r=%b w=%b want 0 0", bus.mem_r_en, bus.mem_w_en);
    end
    checks++;
    if (bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0) begin
      errors++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", bus.mem_address, bus.mem_write_data);
    end
    checks++;
    if (bus.req0_rdata !== 32'h0 || bus.req1_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.req0_rdata, bus.req1_rdata);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.freeze !== 1'b0 || bus.mem_r_en !== 1'b0) begin
      errors++; $display("FAIL idle_quiet: got freeze=%b r=%b want 0 0", bus.freeze, bus.mem_r_en);
    end
  endtask

  task automatic test_read();
    int lat, wen, ren, frz;
    do_access(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, wen, ren, frz);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
    checks++;
    if (frz !== 3) begin errors++; $display("FAIL read_freeze: got %0d want 3", frz); end
    checks++;
    if (ren !== WC || wen !== 0) begin
      errors++; $display("FAIL read_strobes: got r=%0d w=%0d want %0d 0", ren, wen, WC);
    end
    checks++;
    if (bus.req0_rdata !== 32'h01020304) begin
      errors++; $display("FAIL read_data: got %h want 01020304", bus.req0_rdata);
    end
  endtask

  task automatic test_write_then_read();
    int lat, wen, ren, frz;
    do_access(1, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, lat, wen, ren, frz);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d want 3", lat); end
    checks++;
    if (wen !== 1 || ren !== 0) begin
      errors++; $display("FAIL write_strobes: got w=%0d r=%0d want 1 0", wen, ren);
    end
    checks++;
    if (bus.req1_rdata !== 32'h0) begin
      errors++; $display("FAIL write_rdata1: got %h want 00000000", bus.req1_rdata);
    end
    do_access(0, 1'b1, 1'b0, 32'h8, 32'h0, lat, wen, ren, frz);
    checks++;
    if (bus.req0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL readback: got %h want deadbeef", bus.req0_rdata);
    end
  endtask

  task automatic test_simultaneous();
    int r0_at = -1;
    int r1_at = -1;
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 32'h4, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int k = 1; k <= 20 && r1_at < 0; k++) begin
      @(negedge clock);
      if (bus.ready0) begin r0_at = k; bus.req0_rd = 1'b0; end
      if (bus.ready1) begin r1_at = k; bus.req1_rd = 1'b0; end
    end
    clear_reqs();
    @(negedge clock);
    checks++;
    if (r0_at !== 3 || r1_at !== 7) begin
      errors++; $display("FAIL simul_order: got ready0@%0d ready1@%0d want 3 7", r0_at, r1_at);
    end
    checks++;
    if (bus.req0_rdata !== 32'h05060708 || bus.req1_rdata !== 32'h11121314) begin
      errors++; $display("FAIL simul_data: got %h/%h want 05060708/11121314", bus.req0_rdata, bus.req1_rdata);
    end
  endtask

  // Both ports hold requests for 30 cycles; the grant in flight at cycle 30
  // is withdrawn and must still complete at cycle 31.
  task automatic test_back_to_back();
    int n0 = 0;
    int n1 = 0;
    int k31 = -1;
`ifdef MEM_ARB_RR_EN
    int exp_n0 = 4, exp_n1 = 4, exp_k31 = 1;
`else
    int exp_n0 = 8, exp_n1 = 0, exp_k31 = 0;
`endif
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clock);
      if (bus.ready0) n0++;
      if (bus.ready1) n1++;
      if (k == 31) k31 = bus.ready0 ? 0 : (bus.ready1 ? 1 : -1);
      if (k == 30) clear_reqs();
    end
    checks++;
    if (n0 !== exp_n0 || n1 !== exp_n1) begin
      errors++; $display("FAIL b2b_grants: got %0d/%0d want %0d/%0d", n0, n1, exp_n0, exp_n1);
    end
    checks++;
    if (k31 !== exp_k31) begin
      errors++; $display("FAIL withdrawn_completes: got port %0d want %0d", k31, exp_k31);
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    @(negedge clock);
    set_req(1, 1'b0, 1'b1, 32'h20, 32'h55AA55AA);
    @(negedge clock);
    reset = 1'b1;
    clear_reqs();
    #1;
    checks++;
    if (bus.mem_w_en !== 1'b0) begin
      errors++; $display("FAIL abort_wen: got %b want 0", bus.mem_w_en);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k == 1) reset = 1'b0;
      if (bus.ready0 || bus.ready1 || bus.mem_w_en) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_quiet: got %0d want 0", pulses); end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL abort_state: got %0d want %0d", dut.state_q, IDLE);
    end
    checks++;
    if (mem_word(8'h20) !== 32'h21222324) begin
      errors++; $display("FAIL abort_mem: got %h want 21222324", mem_word(8'h20));
    end
  endtask

  task automatic test_rd_wr_both();
    int lat, wen, ren, frz;
    do_access(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, wen, ren, frz);
    do_access(0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, lat, wen, ren, frz);
    checks++;
    if (wen !== 1 || ren !== 0) begin
      errors++; $display("FAIL rdwr_strobes: got w=%0d r=%0d want 1 0", wen, ren);
    end
    checks++;
    if (bus.req0_rdata !== 32'h01020304) begin
      errors++; $display("FAIL rdwr_rdata_kept: got %h want 01020304", bus.req0_rdata);
    end
    do_access(0, 1'b1, 1'b0, 32'h30, 32'h0, lat, wen, ren, frz);
    checks++;
    if (bus.req0_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rdwr_readback: got %h want cafef00d", bus.req0_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_then_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_abort();
    test_rd_wr_both();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
